// File: rtl/alu_pipelined.sv
// rtl/alu_pipelined.sv - handshaked ALU (Plasma MIPS decode) with iterative shift-add MULTU
module alu_pipelined #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       opcode,
   input  logic [5:0]       func,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             readwrite,
   output logic             zero,
   output logic             illegal
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t           state, state_next;
   logic             accept;
   logic             is_mult;
   logic             last_iter;
   logic             cmp_eq, cmp_ne, slt_s, slt_u;
   logic [WIDTH-1:0] alu_res;
   logic             alu_rw, alu_zero, alu_ill;
   logic [WIDTH-1:0] mcand, prod_hi, prod_lo;
   logic [SHW-1:0]   count;
   logic [WIDTH:0]   step_sum;
   logic [WIDTH-1:0] step_hi, step_lo;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = is_mult ? EXEC : DONE;
         EXEC: if (last_iter) state_next = DONE;
         DONE: begin
            if (out_ready) begin
               if (accept) state_next = is_mult ? EXEC : DONE;
               else        state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
      out_valid = (state == DONE);
      accept    = in_valid & in_ready;
   end

   assign slt_s = ($signed(in1) < $signed(in2));
   assign slt_u = (in1 < in2);

   always_comb begin
      alu_res = '0;
      alu_rw  = 1'b0;
      alu_ill = 1'b0;
      is_mult = 1'b0;
      cmp_eq  = 1'b0;
      cmp_ne  = 1'b0;
      case (opcode)
         6'b000000: begin
            alu_rw = 1'b1;
            case (func)
               6'b100000, 6'b100001: alu_res = in1 + in2;
               6'b100010, 6'b100011: alu_res = in1 - in2;
               6'b100100: alu_res = in1 & in2;
               6'b100101: alu_res = in1 | in2;
               6'b100110: alu_res = in1 ^ in2;
               6'b100111: alu_res = ~(in1 | in2);
               6'b101010: alu_res = {{(WIDTH-1){1'b0}}, slt_s};
               6'b101011: alu_res = {{(WIDTH-1){1'b0}}, slt_u};
               6'b000100: alu_res = in2 << in1[SHW-1:0];
               6'b000110: alu_res = in2 >> in1[SHW-1:0];
               6'b000111: alu_res = $signed(in2) >>> in1[SHW-1:0];
               6'b011001: is_mult = 1'b1;
               default: begin
                  alu_rw  = 1'b0;
                  alu_ill = 1'b1;
               end
            endcase
         end
         6'b100011: begin alu_res = in1 + in2; alu_rw = 1'b1; end
         6'b101011: alu_res = in1 + in2;
         6'b000100: begin alu_res = in1 - in2; cmp_eq = 1'b1; end
         6'b000101: begin alu_res = in1 - in2; cmp_ne = 1'b1; end
         default:   alu_ill = 1'b1;
      endcase
      if (alu_ill)     alu_zero = 1'b0;
      else if (cmp_eq) alu_zero = (in1 == in2);
      else if (cmp_ne) alu_zero = (in1 != in2);
      else             alu_zero = (alu_res == '0);
   end

   // One shift-add step: add multiplicand into the high half, then shift {hi,lo} right.
   assign step_sum  = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
   assign step_hi   = step_sum[WIDTH:1];
   assign step_lo   = {step_sum[0], prod_lo[WIDTH-1:1]};
   assign last_iter = (state == EXEC) && (count == SHW'(WIDTH-1));

   always_ff @(posedge clk) begin
      if (reset) begin
         result    <= '0;
         result_hi <= '0;
         readwrite <= 1'b0;
         zero      <= 1'b0;
         illegal   <= 1'b0;
         mcand     <= '0;
         prod_hi   <= '0;
         prod_lo   <= '0;
         count     <= '0;
      end else if (accept) begin
         if (is_mult) begin
            mcand   <= in1;
            prod_lo <= in2;
            prod_hi <= '0;
            count   <= '0;
         end else begin
            result    <= alu_res;
            result_hi <= '0;
            readwrite <= alu_rw;
            zero      <= alu_zero;
            illegal   <= alu_ill;
         end
      end else if (state == EXEC) begin
         prod_hi <= step_hi;
         prod_lo <= step_lo;
         count   <= count + 1'b1;
         if (last_iter) begin
            result    <= step_lo;
            result_hi <= step_hi;
            readwrite <= 1'b1;
            zero      <= (step_lo == '0);
            illegal   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_pipelined.sv
// tb/tb_alu_pipelined.sv - self-checking bench for alu_pipelined against a behavioural model
module tb_alu_pipelined;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  opcode;
   logic [5:0]  func;
   logic [31:0] in1, in2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result, result_hi;
   logic        readwrite, zero, illegal;

   alu_pipelined #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .func(func), .in1(in1), .in2(in2),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .result_hi(result_hi), .readwrite(readwrite), .zero(zero), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [31:0] hi;
      logic        rw;
      logic        zero;
      logic        ill;
      int          lat;
      int          ready;
   } exp_t;

   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   exp_t exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Reference semantics straight from the instruction set, using wide arithmetic for the product.
   function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                  input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic [63:0] p;
      int k;
      k = int'(a[4:0]);
      e.res = 0; e.hi = 0; e.rw = 0; e.ill = 0; e.lat = 1; e.ready = 0;
      case (op)
         6'h00: begin
            e.rw = 1;
            case (fn)
               6'h20, 6'h21: e.res = a + b;
               6'h22, 6'h23: e.res = a - b;
               6'h24: e.res = a & b;
               6'h25: e.res = a | b;
               6'h26: e.res = a ^ b;
               6'h27: e.res = ~(a | b);
               6'h2A: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               6'h2B: e.res = (a < b) ? 32'd1 : 32'd0;
               6'h04: e.res = b << k;
               6'h06: e.res = b >> k;
               6'h07: e.res = 32'($signed(b) >>> k);
               6'h19: begin
                  p = {32'd0, a} * {32'd0, b};
                  e.res = p[31:0];
                  e.hi  = p[63:32];
                  e.lat = 33;
               end
               default: begin e.rw = 0; e.ill = 1; end
            endcase
         end
         6'h23: begin e.res = a + b; e.rw = 1; end
         6'h2B: e.res = a + b;
         6'h04, 6'h05: e.res = a - b;
         default: e.ill = 1;
      endcase
      if (e.ill)          e.zero = 0;
      else if (op == 6'h04) e.zero = (a == b);
      else if (op == 6'h05) e.zero = (a != b);
      else                e.zero = (e.res == 0);
      return e;
   endfunction

   logic exp_ov, exp_ir;
   exp_t ne;

   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
      end else begin
         exp_ov = (exp_q.size() > 0) && (cyc >= exp_q[0].ready);
         exp_ir = (exp_q.size() == 0) || (exp_ov && out_ready);
         chk("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
         chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ir});
         if (exp_ov && out_valid) begin
            chk("result", {32'd0, result}, {32'd0, exp_q[0].res});
            chk("result_hi", {32'd0, result_hi}, {32'd0, exp_q[0].hi});
            chk("readwrite", {63'd0, readwrite}, {63'd0, exp_q[0].rw});
            chk("zero", {63'd0, zero}, {63'd0, exp_q[0].zero});
            chk("illegal", {63'd0, illegal}, {63'd0, exp_q[0].ill});
         end
         if (exp_ov && out_ready) void'(exp_q.pop_front());
         if (in_valid && exp_ir) begin
            ne = model(opcode, func, in1, in2);
            ne.ready = cyc + ne.lat;
            exp_q.push_back(ne);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; returns just after the edge that accepted the op.
   task automatic send(input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
      int n;
      opcode = op; func = fn; in1 = a; in2 = b; in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) begin
         tests++; fails++;
         $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
      end
      tick();
   endtask

   localparam logic [5:0] R = 6'h00;
   localparam int NT = 12;
   logic [5:0]  t_op [NT] = '{R, R, R, R, R, R, R, R, 6'h23, R, R, 6'h3A};
   logic [5:0]  t_fn [NT] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h04, 6'h06,
                              6'h00, 6'h19, 6'h3F, 6'h00};
   logic [31:0] t_a  [NT] = '{32'h7FFFFFFF, 32'h0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFF0000,
                              32'h0, 32'd31, 32'd8, 32'h1000, 32'd12345, 32'd1, 32'd2};
   logic [31:0] t_b  [NT] = '{32'h1, 32'h1, 32'h0FF00FF0, 32'h0F0F0F0F, 32'h00FFFF00,
                              32'h0, 32'h1, 32'h80000000, 32'hFFFFFFFC, 32'd678, 32'd2, 32'd3};

   exp_t m;
   int   c0, n, nbusy;

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      opcode = 0; func = 0; in1 = 0; in2 = 0;

      // Hand-computed values that pin the model.
      m = model(R, 6'h20, 32'hFFFFFFFF, 32'h1);
      chk("model_add", {m.res, 31'd0, m.zero}, {32'h0, 32'h1});
      m = model(R, 6'h22, 32'd5, 32'd7);        chk("model_sub", {32'd0, m.res}, {32'd0, 32'hFFFFFFFE});
      m = model(R, 6'h2A, 32'hFFFFFFFE, 32'd1); chk("model_slt", {32'd0, m.res}, 64'd1);
      m = model(R, 6'h2B, 32'hFFFFFFFE, 32'd1); chk("model_sltu", {32'd0, m.res}, 64'd0);
      m = model(R, 6'h07, 32'd4, 32'h80000000); chk("model_srav", {32'd0, m.res}, {32'd0, 32'hF8000000});
      m = model(R, 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
      chk("model_multu", {m.hi, m.res}, {32'hFFFFFFFE, 32'h00000001});
      m = model(6'h05, 0, 32'd9, 32'd9);        chk("model_bne", {63'd0, m.zero}, 64'd0);
      m = model(6'h2B, 0, 32'h100, 32'h4);      chk("model_sw", {31'd0, m.rw, m.res}, {32'd0, 32'h104});

      repeat (3) tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_result", {result_hi, result}, 64'd0);
      tick();

      // Reset in the middle of a multiply.
      send(R, 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
      in_valid = 1'b0;
      repeat (5) tick();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("midrst_result", {result_hi, result}, 64'd0);
      tick();
      send(R, 6'h20, 32'd3, 32'd4);
      in_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_add", {32'd0, result}, 64'd7);
      tick();

      // ADD wrap.
      send(R, 6'h20, 32'hFFFFFFFF, 32'h1);
      in_valid = 1'b0;
      @(negedge clk);
      chk("add_wrap", {29'd0, out_valid, zero, readwrite, result}, {29'd0, 3'b111, 32'h0});
      tick();

      // Back-to-back stream.
      c0 = cyc;
      send(R, 6'h22, 32'd5, 32'd7);
      send(R, 6'h2A, 32'hFFFFFFFE, 32'd1);
      send(R, 6'h2B, 32'hFFFFFFFE, 32'd1);
      send(R, 6'h07, 32'd4, 32'h80000000);
      in_valid = 1'b0;
      chk("b2b_cycles", 64'(cyc - c0), 64'd4);
      @(negedge clk);
      chk("b2b_srav", {32'd0, result}, {32'd0, 32'hF8000000});
      tick();

      // MULTU latency and product.
      send(R, 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
      in_valid = 1'b0;
      n = 0; nbusy = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin
         if (!in_ready) nbusy++;
         n++;
         @(negedge clk);
      end
      chk("multu_wait", 64'(n), 64'd32);
      chk("multu_busy", 64'(nbusy), 64'd32);
      chk("multu_prod", {result_hi, result}, {32'hFFFFFFFE, 32'h00000001});
      tick();

      // BEQ held under backpressure, then BNE.
      out_ready = 1'b0;
      send(6'h04, 6'h00, 32'd9, 32'd9);
      opcode = 6'h05; in1 = 32'd9; in2 = 32'd9; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("beq_hold", {29'd0, in_ready, zero, readwrite, result}, {29'd0, 3'b010, 32'h0});
      end
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      chk("beq_release", {63'd0, in_ready}, 64'd1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("bne_zero", {62'd0, out_valid, zero}, 64'b10);
      tick();

      // Illegal opcode then SW.
      send(6'h3F, 6'h00, 32'h55, 32'h66);
      in_valid = 1'b0;
      @(negedge clk);
      chk("illegal_op", {29'd0, out_valid, illegal, readwrite, result}, {29'd0, 3'b110, 32'h0});
      tick();
      send(6'h2B, 6'h00, 32'h100, 32'h4);
      in_valid = 1'b0;
      @(negedge clk);
      chk("sw_after_ill", {30'd0, illegal, readwrite, result}, {32'd0, 32'h104});
      tick();

      // Mixed stream, checked by the model alone.
      for (int i = 0; i < NT; i++) send(t_op[i], t_fn[i], t_a[i], t_b[i]);
      in_valid = 1'b0;
      n = 0;
      while (exp_q.size() > 0 && n < 100) begin
         n++;
         tick();
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_pipelined.md
Name: alu_pipelined

Overview:
Parametrised, handshaked successor to the combinational datapath ALU. It accepts one operation per valid/ready transfer and decodes opcode/func using the Plasma MIPS encoding. Single-cycle operations return a registered result one cycle later. MULTU runs on an iterative shift-add multiplier. It sits between register-file read and writeback, and provides a branch-compare flag for the fetch unit.

Parameters:
WIDTH, 32, datapath width in bits (>=8, power of 2)
SHW, $clog2(WIDTH), shift-amount width taken from in1 for variable shifts

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  operation presented
in_ready  out  1  block can accept an operation this cycle
opcode  in  6  MIPS opcode
func  in  6  MIPS function field (used when opcode==000000)
in1  in  WIDTH  operand A (rs)
in2  in  WIDTH  operand B (rt or sign-extended immediate)
out_valid  out  1  result registers hold a completed operation
out_ready  in  1  consumer takes result
result  out  WIDTH  primary result / low half of product
result_hi  out  WIDTH  high half of MULTU product, else 0
readwrite  out  1  1 = writeback to register file, 0 = no write
zero  out  1  result==0 (branch-taken flag for BEQ; inverted sense for BNE)
illegal  out  1  unsupported opcode/func completed

Behaviour:
- Synchronous, active-high reset on clk. State returns to IDLE. All outputs go to 0 except in_ready=1, even mid-MULTU; any partial product is discarded.
- FSM states: IDLE, EXEC, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready. Operands are latched on accept.
- Single-cycle ops go to DONE with the result registered; out_valid=1 on the next cycle (latency 1).
- MULTU (opcode 000000, func 011001) enters EXEC and runs WIDTH iterations of shift-add. It moves to DONE after WIDTH cycles in EXEC, so out_valid rises WIDTH+1 cycles after accept. in_ready=0 during EXEC.
- DONE holds every output stable while out_ready=0.
- In DONE, if out_ready=1 and in_valid=0: go to IDLE, out_valid=0 next cycle.
- In DONE, if out_ready=1 and in_valid=1: back-to-back. The new op is accepted in the same cycle. Sustained throughput is 1 op/cycle for single-cycle ops.
- R-type functions (opcode 000000), all with readwrite=1, wrap modulo 2^WIDTH, no overflow trap:
  - ADD 100000 / ADDU 100001: in1+in2
  - SUB 100010 / SUBU 100011: in1-in2
  - AND 100100, OR 100101, XOR 100110, NOR 100111: bitwise
  - SLT 101010: signed in1<in2 ? 1 : 0
  - SLTU 101011: unsigned compare, same result encoding as SLT
  - SLLV 000100: in2 << in1[SHW-1:0]
  - SRLV 000110: logical right shift by in1[SHW-1:0]
  - SRAV 000111: arithmetic right shift by in1[SHW-1:0]
  - MULTU 011001: {result_hi,result} = in1*in2 unsigned
- LW 100011: result=in1+in2, readwrite=1.
- SW 101011: result=in1+in2, readwrite=0.
- BEQ 000100: result=in1-in2, readwrite=0, zero=(in1==in2).
- BNE 000101: result=in1-in2, readwrite=0, zero=(in1!=in2).
- For every other op, zero=(result==0).
- Any other opcode/func: result=0, result_hi=0, readwrite=0, zero=0, illegal=1, latency 1. It still completes the handshake.
- result_hi=0 for every non-MULTU op.
- in1/in2/opcode/func changes while not accepting have no effect.

Test Plan:
1. Reset held 2 cycles during MULTU EXEC -> next cycle state IDLE, out_valid=0, in_ready=1, result=0. The op accepted after reset completes normally.
2. ADD in1=0xFFFFFFFF in2=0x00000001, out_ready=1 -> next cycle out_valid=1, result=0x00000000, zero=1, readwrite=1.
3. Back-to-back stream SUB(5,7), SLT(0xFFFFFFFE,1), SLTU(0xFFFFFFFE,1), SRAV(in1=4,in2=0x80000000), in_valid held, out_ready=1 -> results 0xFFFFFFFE, 1, 0, 0xF8000000 on 4 consecutive cycles. in_ready stays 1 throughout.
4. MULTU in1=0xFFFFFFFF in2=0xFFFFFFFF -> in_ready=0 for 32 cycles. out_valid rises at cycle 33 with result=0x00000001, result_hi=0xFFFFFFFE.
5. BEQ(9,9) then BNE(9,9) with out_ready low 3 cycles -> BEQ outputs (zero=1, readwrite=0, result=0) hold stable and in_ready=0 until out_ready rises. BNE then yields zero=0.
6. opcode=111111 -> illegal=1, result=0, readwrite=0, out_valid after 1 cycle. The following SW(0x100,0x4) gives result=0x104, readwrite=0, illegal=0.
